// File: rtl/exp_rom_loader_if.sv
// ioctl download stream, SDRAM boot-write port and loaded-page bitmap query
// for exp_rom_loader. The master is the HPS/host side; the slave is the loader.
interface exp_rom_loader_if #(
  parameter int BANKS     = 2,
  parameter int PAGE_BITS = 8
);
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic                 ce_ref;
  logic                 ioctl_download;
  logic                 ioctl_wr;
  logic [24:0]          ioctl_addr;
  logic [7:0]           ioctl_dout;
  logic [7:0]           ioctl_index;
  logic [31:0]          ioctl_file_ext;
  logic                 ioctl_wait;
  logic                 boot_wr;
  logic [22:0]          boot_a;
  logic [BANK_W-1:0]    boot_bank;
  logic [7:0]           boot_dout;
  logic                 map_clr;
  logic [PAGE_BITS-1:0] map_addr;
  logic                 map_hit;
  logic                 bad_ext;

  modport master (
    output ce_ref, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
           ioctl_index, ioctl_file_ext, map_clr, map_addr,
    input  ioctl_wait, boot_wr, boot_a, boot_bank, boot_dout, map_hit, bad_ext
  );

  modport slave (
    input  ce_ref, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
           ioctl_index, ioctl_file_ext, map_clr, map_addr,
    output ioctl_wait, boot_wr, boot_a, boot_bank, boot_dout, map_hit, bad_ext
  );
endinterface

// File: rtl/exp_rom_loader.sv
// Boot/expansion ROM download path: turns ioctl bytes into ce_ref-paced SDRAM
// writes, mirrors expansion ROMs across banks and tracks loaded ROM pages.
module exp_rom_loader #(
  parameter int         BANKS     = 2,
  parameter int         PAGE_BITS = 8,
  parameter logic [8:0] MF2_PAGE  = 9'h1FF,
  parameter logic [8:0] BAD_PAGE  = 9'h1EE
) (
  input  logic             clk_sys,
  input  logic             reset,
  exp_rom_loader_if.slave  bus
);
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int MAP_N  = 1 << PAGE_BITS;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WRITE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_dl_d;
  logic                 r_wait;
  logic                 r_wr;
  logic [22:0]          r_a;
  logic [BANK_W-1:0]    r_bank;
  logic [7:0]           r_dout;
  logic [8:0]           r_page;
  logic                 r_combo;
  logic                 r_bad;
  logic                 r_map_hit;
  logic [MAP_N-1:0]     r_bitmap;

  logic                 w_is_exp;
  logic                 w_mirror;
  logic                 w_dl_start;
  logic [10:0]          w_slot;
  logic                 w_sys_ok;
  logic [8:0]           w_sys_page;
  logic [8:0]           w_exp_page;
  logic [4:0]           w_hi;
  logic [4:0]           w_lo;
  logic [8:0]           w_start_page;
  logic                 w_start_bad;
  logic                 w_start_combo;
  logic                 w_take;
  logic                 w_accept;
  logic                 w_arm_fire;
  logic                 w_write_fire;
  logic                 w_next_bank;
  logic                 w_done;
  logic                 w_unused_ext;

  // {valid, value} for one ASCII hex digit, upper case only
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else                               return 5'b0;
  endfunction

  assign w_unused_ext = ^bus.ioctl_file_ext[31:16];

  assign w_is_exp   = (bus.ioctl_index != 8'd0);
  assign w_mirror   = w_is_exp &&
                      (bus.ioctl_index[7:6] == 2'b01 || bus.ioctl_index[5:0] != 6'd0);
  assign w_dl_start = bus.ioctl_download && !r_dl_d && w_is_exp;
  assign w_slot     = bus.ioctl_addr[24:14];
  assign w_sys_ok   = int'(w_slot) < 4 * BANKS;
  assign w_exp_page = r_page + {1'b0, bus.ioctl_addr[21:14]};
  assign w_take     = (r_state == S_IDLE) && bus.ioctl_wr && bus.ioctl_download;
  assign w_hi       = hex_nib(bus.ioctl_file_ext[15:8]);
  assign w_lo       = hex_nib(bus.ioctl_file_ext[7:0]);

  always_comb begin
    w_sys_page = 9'h000;
    case (w_slot[1:0])
      2'd0:    w_sys_page = 9'h000;
      2'd1:    w_sys_page = 9'h100;
      2'd2:    w_sys_page = 9'h107;
      default: w_sys_page = 9'h1FF;
    endcase
  end

  // Invalid characters leave the matching BAD_PAGE nibble in place
  always_comb begin
    w_start_page  = BAD_PAGE;
    w_start_bad   = !(w_hi[4] && w_lo[4]);
    w_start_combo = 1'b0;
    if (w_hi[4]) w_start_page[7:4] = w_hi[3:0];
    if (w_lo[4]) w_start_page[3:0] = w_lo[3:0];
    if (bus.ioctl_file_ext[15:0] == 16'h5A5A) begin
      w_start_page = 9'h000;
      w_start_bad  = 1'b0;
    end else if (bus.ioctl_file_ext[15:0] == 16'h5A30) begin
      w_start_page  = 9'h000;
      w_start_bad   = 1'b0;
      w_start_combo = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_arm_fire   = 1'b0;
    w_write_fire = 1'b0;
    w_next_bank  = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take && (w_is_exp || w_sys_ok)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (bus.ce_ref) begin
          w_arm_fire  = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.ce_ref) begin
          w_write_fire = 1'b1;
          if (w_mirror && int'(r_bank) < BANKS - 1) begin
            w_next_bank = 1'b1;
            w_state_nxt = S_ARM;
          end else begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dl_d  <= 1'b0;
      r_wait  <= 1'b0;
      r_wr    <= 1'b0;
      r_a     <= '0;
      r_bank  <= '0;
      r_dout  <= '0;
      r_page  <= '0;
      r_combo <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_dl_d <= bus.ioctl_download;
      if (w_take) begin
        r_dout     <= bus.ioctl_dout;
        r_a[13:0]  <= bus.ioctl_addr[13:0];
      end
      if (w_accept) begin
        r_wait <= 1'b1;
        if (w_is_exp) begin
          r_a[22:14] <= w_exp_page;
          r_bank     <= '0;
        end else begin
          r_a[22:14] <= w_sys_page;
          r_bank     <= w_slot[BANK_W+1:2];
        end
      end
      if (w_arm_fire)   r_wr <= 1'b1;
      if (w_write_fire) r_wr <= 1'b0;
      if (w_next_bank)  r_bank <= r_bank + 1'b1;
      if (w_done) begin
        r_wait <= 1'b0;
        // Last byte of the first 16 KB combo chunk switches to the MF2 page
        if (r_combo && r_a[13:0] == 14'h3FFF) begin
          r_combo <= 1'b0;
          r_page  <= MF2_PAGE;
        end
      end
      if (w_dl_start) begin
        r_page  <= w_start_page;
        r_combo <= w_start_combo;
        r_bad   <= w_start_bad;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_bitmap  <= '0;
      r_map_hit <= 1'b0;
    end else begin
      if (bus.map_clr)
        r_bitmap <= '0;
      else if (w_done && r_a[22])
        r_bitmap[r_a[14 +: PAGE_BITS]] <= 1'b1;
      r_map_hit <= r_bitmap[bus.map_addr];
    end
  end

  assign bus.ioctl_wait = r_wait;
  assign bus.boot_wr    = r_wr;
  assign bus.boot_a     = r_a;
  assign bus.boot_bank  = r_bank;
  assign bus.boot_dout  = r_dout;
  assign bus.map_hit    = r_map_hit;
  assign bus.bad_ext    = r_bad;
endmodule
